// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU and the ALU control decoder.
//   alu_op_t    - 4-bit ALU control code
//   alu_state_t - execute FSM state (SHIFT exists only with ALU_SHIFT_EN)
//   XLEN_DEFAULT - default datapath width
// Optional feature macro: ALU_SHIFT_EN
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0100
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DONE  = 2'd1
`ifdef ALU_SHIFT_EN
    ,
    ST_SHIFT = 2'd2
`endif
  } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU evaluation.
//   i_op     [3:0]  ALU control code
//   i_a, i_b [XLEN] operands
//   o_result [XLEN] AND/OR/ADD/SUB result; 0 for any other code (shift codes
//                   included -- shifts are handled by the iterative path)
module alu_core import alu_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;  // wraps, carry dropped
      ALU_SUB: o_result = i_a - i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake.
//   clk, rst_n            clock, async active-low reset
//   flush                 sync abort of in-flight/pending op
//   inValid/inReady       request handshake (aluControl, operandA, operandB)
//   outValid/outReady     result handshake (aluResult, zero)
// Optional feature macro: ALU_SHIFT_EN -- adds iterative SLL/SRL (1 bit/cycle)
// through a SHIFT state; without it shift codes behave as invalid codes.
module alu_exec_unit import alu_pkg::*; #(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [3:0]      aluControl,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] aluResult,
  output logic            zero
);

  if ((1 << SHAMT_W) != XLEN) begin : g_bad_shamt_w
    $error("alu_exec_unit: SHAMT_W must equal log2(XLEN)");
  end

  alu_state_t      r_state, w_state_nxt, w_xfer_st;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic [XLEN-1:0] w_core_res;
  logic [XLEN-1:0] w_load_val;
  logic            w_xfer;

  alu_core #(.XLEN(XLEN)) u_core (
    .i_op     (aluControl),
    .i_a      (operandA),
    .i_b      (operandB),
    .o_result (w_core_res)
  );

  // A request presented during flush is dropped.
  assign w_xfer = inValid && inReady && !flush;

`ifdef ALU_SHIFT_EN
  logic [XLEN-1:0]    r_shreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_shl;
  logic               w_is_shift, w_go_shift;
  logic [XLEN-1:0]    w_sh_nxt;

  assign w_is_shift = (aluControl == ALU_SLL) || (aluControl == ALU_SRL);
  // shamt 0 short-circuits to DONE with operandA as the result
  assign w_go_shift = w_is_shift && (operandB[SHAMT_W-1:0] != '0);
  assign w_load_val = w_is_shift ? operandA : w_core_res;
  assign w_xfer_st  = w_go_shift ? ST_SHIFT : ST_DONE;
  assign w_sh_nxt   = r_shl ? (r_shreg << 1) : (r_shreg >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_shl   <= 1'b0;
    end else if (flush) begin
      r_cnt   <= '0;
    end else if (w_xfer && w_go_shift) begin
      r_shreg <= operandA;
      r_cnt   <= operandB[SHAMT_W-1:0];
      r_shl   <= (aluControl == ALU_SLL);
    end else if (r_state == ST_SHIFT) begin
      r_shreg <= w_sh_nxt;
      r_cnt   <= r_cnt - SHAMT_W'(1);
    end
  end
`else
  assign w_load_val = w_core_res;
  assign w_xfer_st  = ST_DONE;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_xfer) w_state_nxt = w_xfer_st;
        // in DONE a transfer implies outReady (inReady passes it through)
        ST_DONE: if (outReady) w_state_nxt = w_xfer ? w_xfer_st : ST_IDLE;
`ifdef ALU_SHIFT_EN
        ST_SHIFT: if (r_cnt == SHAMT_W'(1)) w_state_nxt = ST_DONE;
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    case (r_state)
      ST_IDLE: inReady = 1'b1;
      ST_DONE: begin
        outValid = 1'b1;
        inReady  = outReady;
      end
      default: ;
    endcase
  end

  // Result/zero register: only written on completion, never cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b1;
`ifdef ALU_SHIFT_EN
    end else if (w_xfer && !w_go_shift) begin
      r_result <= w_load_val;
      r_zero   <= (w_load_val == '0);
    end else if (!flush && r_state == ST_SHIFT && r_cnt == SHAMT_W'(1)) begin
      r_result <= w_sh_nxt;
      r_zero   <= (w_sh_nxt == '0);
    end
`else
    end else if (w_xfer) begin
      r_result <= w_load_val;
      r_zero   <= (w_load_val == '0);
    end
`endif
  end

  assign aluResult = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes expected
// result/zero/latency at each transfer; a negedge monitor compares.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [3:0]  aluControl = 4'h0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] aluResult;
  logic        zero;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .aluControl(aluControl), .operandA(operandA), .operandB(operandB),
    .outValid(outValid), .outReady(outReady),
    .aluResult(aluResult), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          cyc0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;
  bit head_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency checked the first cycle a result is visible,
  // value checked when the result handshake completes.
  always @(negedge clk) begin
    if (rst_n && outValid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: outValid with no pending op, aluResult=%h (t=%0t)",
                 aluResult, $time);
      end else begin
        if (!head_seen) begin
          chk("latency", 32'(cyc - sb[0].cyc0), 32'(sb[0].lat));
          head_seen = 1'b1;
        end
        if (outReady) begin
          chk("result", aluResult, sb[0].res);
          chk("zero", {31'b0, zero}, {31'b0, sb[0].z});
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, push expectation.
  // Called and returns at posedge+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic z, input int lat, input bit push,
                       output int waited, output int xcyc);
    exp_t e;
    aluControl = op; operandA = a; operandB = b; inValid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!inReady && waited < 60) begin
      waited++;
      @(negedge clk);
    end
    xcyc = cyc;
    if (!inReady) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout: op %h never accepted", op);
    end else if (push) begin
      e.res = exp; e.z = z; e.lat = lat; e.cyc0 = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    // scramble operands after the transfer to prove they are not re-sampled
    inValid = 1'b0; aluControl = 4'hF; operandA = 32'hA5A5_5A5A; operandB = 32'h0000_0003;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c1, c2, c3;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inReady", {31'b0, inReady}, 32'd1);
    chk("rst_outValid", {31'b0, outValid}, 32'd0);
    chk("rst_aluResult", aluResult, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SUB
    issue(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1, 1, w, c1);
    issue(4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 1, w, c1);

    // Back-to-back stream, one per cycle
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1, w, c1);
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1, 1, w, c2);
    issue(4'b0001, 32'h1, 32'h2, 32'h3, 1'b0, 1, 1, w, c3);
    chk("stream_gap1", 32'(c2 - c1), 32'd1);
    chk("stream_gap2", 32'(c3 - c2), 32'd1);
    drain();

    // Invalid codes
    issue(4'b1111, 32'd7, 32'd9, 32'd0, 1'b1, 1, 1, w, c1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1, w, c1);

`ifdef ALU_SHIFT_EN
    issue(4'b0011, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32, 1, w, c1);
    issue(4'b0100, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 5, 1, w, c1);
    issue(4'b0011, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1, 1, w, c1);
    issue(4'b0100, 32'hCAFE_0000, 32'h0000_0020, 32'hCAFE_0000, 1'b0, 1, 1, w, c1);
    issue(4'b0100, 32'h1, 32'd1, 32'd0, 1'b1, 2, 1, w, c1);
`else
    issue(4'b0011, 32'h1, 32'd4, 32'd0, 1'b1, 1, 1, w, c1);
    issue(4'b0100, 32'h8000_0000, 32'd4, 32'd0, 1'b1, 1, 1, w, c1);
`endif
    drain();

    // Backpressure: result held, requests refused for 4 cycles
    outReady = 1'b0;
    issue(4'b0010, 32'd7, 32'd8, 32'd15, 1'b0, 1, 1, w, c1);
    aluControl = 4'b0110; operandA = 32'd10; operandB = 32'd3; inValid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_outValid", {31'b0, outValid}, 32'd1);
      chk("bp_inReady", {31'b0, inReady}, 32'd0);
      chk("bp_aluResult", aluResult, 32'd15);
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    issue(4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, 1, 1, w, c1);
    chk("bp_accept_same_cycle", 32'(w), 32'd0);
    drain();

    // Request presented with flush is dropped; aluResult kept
    aluControl = 4'b0010; operandA = 32'd1; operandB = 32'd2; inValid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flushreq_outValid", {31'b0, outValid}, 32'd0);
    end
    chk("flushreq_inReady", {31'b0, inReady}, 32'd1);
    chk("flushreq_keep_result", aluResult, 32'd7);
    @(posedge clk); #1;

`ifdef ALU_SHIFT_EN
    // flush at cycle 3 of SLL by 10
    issue(4'b0011, 32'h1, 32'd10, 32'd0, 1'b0, 0, 0, w, c1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushsh_inReady", {31'b0, inReady}, 32'd1);
    repeat (12) begin
      @(negedge clk);
      chk("flushsh_outValid", {31'b0, outValid}, 32'd0);
    end
    @(posedge clk); #1;
    issue(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1, w, c1);
    drain();

    // Reset mid-SHIFT
    issue(4'b0011, 32'd3, 32'd20, 32'd0, 1'b0, 0, 0, w, c1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstsh_inReady", {31'b0, inReady}, 32'd1);
    chk("rstsh_outValid", {31'b0, outValid}, 32'd0);
    chk("rstsh_aluResult", aluResult, 32'd0);
    chk("rstsh_zero", {31'b0, zero}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'b0010, 32'h10, 32'h20, 32'h30, 1'b0, 1, 1, w, c1);
`endif

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
